// File: rtl/wb_pkg.sv
// Shared widths, source select and FIFO entry layout for the writeback stage.
package wb_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MD
  } src_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } md_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered count; a push is poppable next cycle.
// Contents are not reset; the pointers and count define validity.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU priority, buffered mult/div, starve guard, scoreboard.
// Define WB_BYPASS_EN to let an md result skip the empty FIFO.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                alu_valid,
  input  logic [REG_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                stall_alu,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [REG_W-1:0]    md_rd,
  input  logic [DATA_W-1:0]   md_data,
  input  logic                md_issue,
  input  logic [REG_W-1:0]    md_issue_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                ctrl_writeEnable,
  output logic [REG_W-1:0]    ctrl_writeReg,
  output logic [DATA_W-1:0]   data_writeReg
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]       starve;
  logic                live;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  md_entry_t           head;
  md_entry_t           md_in;
  logic                alu_win;
  logic                pop;
  logic                push;
  logic                bypass;
  src_e                src;
  logic [REG_W-1:0]    sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] set_v;
  logic [NUM_REGS-1:0] clr_v;
  logic [NUM_REGS-1:0] pending_n;

  assign md_in     = '{rd: md_rd, data: md_data};
  assign stall_alu = (starve == SW'(STARVE_LIMIT));
  assign md_ready  = live & ~full;
  assign alu_win   = alu_valid & ~stall_alu;
  assign pop       = ~alu_win & ~empty;
`ifdef WB_BYPASS_EN
  assign bypass = empty & ~alu_valid & ~stall_alu & md_valid & md_ready;
`else
  assign bypass = 1'b0;
`endif
  assign push = md_valid & md_ready & ~bypass;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (REG_W + DATA_W)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (ctrl_reset),
    .push    (push),
    .pop     (pop),
    .wr_data (md_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      alu_win: begin
        src      = SRC_ALU;
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      pop: begin
        src      = SRC_MD;
        sel_rd   = head.rd;
        sel_data = head.data;
      end
      bypass: begin
        src      = SRC_MD;
        sel_rd   = md_in.rd;
        sel_data = md_in.data;
      end
      default: ;
    endcase
  end

  // set beats clear so a reissue to the draining rd stays pending
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (md_issue && md_issue_rd != '0) set_v[md_issue_rd] = 1'b1;
    if (src == SRC_MD && sel_rd != '0) clr_v[sel_rd] = 1'b1;
    pending_n    = (pending & ~clr_v) | set_v;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      live             <= 1'b0;
      starve           <= '0;
      pending          <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      live    <= 1'b1;
      pending <= pending_n;
      if (pop || empty)
        starve <= '0;
      else if (alu_win)
        starve <= starve + 1'b1;
      ctrl_writeEnable <= (src != SRC_NONE) && (sel_rd != '0);
      ctrl_writeReg    <= sel_rd;
      data_writeReg    <= sel_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) assert (count <= CW'(DEPTH));
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU vector table plus md/starve/reset sequences.
module tb_wb_arbiter;
  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        stall_alu;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic [31:0] pending;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        av;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[5];

  always #5 clock = ~clock;

  wb_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .stall_alu        (stall_alu),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_issue         (md_issue),
    .md_issue_rd      (md_issue_rd),
    .pending          (pending),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_wr(input string name, input logic [4:0] r,
                        input logic [31:0] d);
    chk({name, "_we"}, 32'(ctrl_writeEnable), 32'd1);
    chk({name, "_reg"}, 32'(ctrl_writeReg), 32'(r));
    chk({name, "_data"}, data_writeReg, d);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd4,  32'h00000044, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h0};

    ctrl_reset  = 1'b0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    md_valid    = 1'b0;
    md_rd       = '0;
    md_data     = '0;
    md_issue    = 1'b0;
    md_issue_rd = '0;

    // reset state
    tick();
    tick();
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_data", data_writeReg, 32'd0);
    chk("rst_stall", 32'(stall_alu), 32'd0);
    chk("rst_ready", 32'(md_ready), 32'd0);
    chk("rst_pending", pending, 32'd0);
    #2 ctrl_reset = 1'b1;
    tick();
    chk("rel_ready", 32'(md_ready), 32'd1);
    chk("rel_we", 32'(ctrl_writeEnable), 32'd0);

    // ALU vector table
    for (int i = 0; i < 5; i++) begin
      alu_valid = vecs[i].av;
      alu_rd    = vecs[i].rd;
      alu_data  = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_we", i), 32'(ctrl_writeEnable), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_reg", i), 32'(ctrl_writeReg), 32'(vecs[i].wreg));
        chk($sformatf("vec%0d_data", i), data_writeReg, vecs[i].wdata);
      end
    end
    alu_valid = 1'b0;
    tick();

    // issue r7, then md result for r7 with ALU idle
    md_issue    = 1'b1;
    md_issue_rd = 5'd7;
    tick();
    md_issue = 1'b0;
    chk("issue7_pending", pending, 32'h0000_0080);
    md_valid = 1'b1;
    md_rd    = 5'd7;
    md_data  = 32'h55;
    tick();
    md_valid = 1'b0;
`ifndef WB_BYPASS_EN
    chk("md7_early_we", 32'(ctrl_writeEnable), 32'd0);
    chk("md7_early_pending", pending, 32'h0000_0080);
    tick();
`endif
    chk_wr("md7", 5'd7, 32'h55);
    chk("md7_pending", pending, 32'd0);
    tick();

    // fill FIFO under ALU pressure, then starvation drain
    alu_valid = 1'b1;
    alu_rd    = 5'd2;
    alu_data  = 32'h100;
    md_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      md_rd   = 5'(10 + i);
      md_data = 32'hA0 + 32'(i);
      chk($sformatf("fill%0d_ready", i), 32'(md_ready), 32'd1);
      tick();
      chk($sformatf("fill%0d_alu", i), 32'(ctrl_writeReg), 32'd2);
    end
    md_valid = 1'b0;
    chk("full_ready", 32'(md_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("starve%0d_stall", i), 32'(stall_alu), 32'd0);
      chk_wr($sformatf("starve%0d", i), 5'd2, 32'h100);
    end
    tick();
    chk("starve_stall", 32'(stall_alu), 32'd1);
    chk_wr("starve_last_alu", 5'd2, 32'h100);
    tick();
    chk("post_stall", 32'(stall_alu), 32'd0);
    chk_wr("forced_pop", 5'd10, 32'hA0);
    chk("post_pop_ready", 32'(md_ready), 32'd1);
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_wr($sformatf("drain%0d", i), 5'(10 + i), 32'hA0 + 32'(i));
    end
    tick();
    chk("drained_we", 32'(ctrl_writeEnable), 32'd0);
    chk("drained_pending", pending, 32'd0);

    // reissue r9 in the cycle its previous result drains
    md_issue    = 1'b1;
    md_issue_rd = 5'd9;
    tick();
    md_issue = 1'b0;
    md_valid = 1'b1;
    md_rd    = 5'd9;
    md_data  = 32'h99;
`ifdef WB_BYPASS_EN
    md_issue = 1'b1;
    tick();
    md_valid = 1'b0;
    md_issue = 1'b0;
`else
    tick();
    md_valid = 1'b0;
    md_issue = 1'b1;
    tick();
    md_issue = 1'b0;
`endif
    chk_wr("md9", 5'd9, 32'h99);
    chk("md9_pending", pending, 32'h0000_0200);
    tick();

    // reset with 3 queued entries and pending bits
    alu_valid = 1'b1;
    alu_rd    = 5'd2;
    alu_data  = 32'h200;
    md_valid  = 1'b1;
    md_issue  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      md_rd       = 5'(4 + i);
      md_issue_rd = 5'(4 + i);
      md_data     = 32'hC0 + 32'(i);
      tick();
    end
    md_valid = 1'b0;
    md_issue = 1'b0;
    chk("pre_rst_pending", pending, 32'h0000_0270);
    tick();
    chk_wr("pre_rst_alu", 5'd2, 32'h200);
    #2 ctrl_reset = 1'b0;
    #1;
    chk("mid_rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("mid_rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("mid_rst_data", data_writeReg, 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_ready", 32'(md_ready), 32'd0);
    chk("mid_rst_stall", 32'(stall_alu), 32'd0);
    alu_valid = 1'b0;
    tick();
    chk("in_rst_we", 32'(ctrl_writeEnable), 32'd0);
    #2 ctrl_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d_we", i), 32'(ctrl_writeEnable), 32'd0);
      chk($sformatf("post_rst%0d_ready", i), 32'(md_ready), 32'd1);
      chk($sformatf("post_rst%0d_pending", i), pending, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage sitting directly upstream of the 32x32 register file; it owns and drives the regfile's single write port (ctrl_writeEnable, ctrl_writeReg, data_writeReg).
- Merges two result sources:
  - the single-cycle ALU pipeline, which has priority and is never back-pressured except by anti-starvation;
  - the long-latency mult/div unit, which is buffered in a small FIFO behind a valid/ready handshake.
- Keeps a pending-destination scoreboard so the hazard logic can stall reads of registers whose mult/div result has not yet been written.

Parameters:
- DEPTH, 4, mult/div result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive cycles the ALU may win while the FIFO is non-empty before one forced drain cycle.

Ports:
- clock  in  1  rising-edge clock.
- ctrl_reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- stall_alu  out  1  forced-drain cycle; ALU input is ignored and upstream must hold.
- md_valid  in  1  mult/div result offered.
- md_ready  out  1  FIFO can accept.
- md_rd  in  5  mult/div destination.
- md_data  in  32  mult/div result.
- md_issue  in  1  mult/div op issued (sets scoreboard).
- md_issue_rd  in  5  destination of the issued op.
- pending  out  32  scoreboard; bit i=1 means a mult/div write to ri is outstanding.
- ctrl_writeEnable  out  1  to regfile.
- ctrl_writeReg  out  5  to regfile.
- data_writeReg  out  32  to regfile.

Behaviour:
- Reset (ctrl_reset=0, async): all outputs 0; FIFO empty; starve counter 0; pending=0.
  - md_ready goes 1 on the first clock after release.
- All regfile outputs are registered; the selection made in cycle N appears on the write port in cycle N+1.
- Selection priority, evaluated each cycle:
  1. stall_alu=0 and alu_valid: ALU wins.
  2. Otherwise, FIFO non-empty: pop the head.
  3. Otherwise: idle, ctrl_writeEnable=0 next cycle.
- Register 0 handling:
  - A selected write with rd=0 produces ctrl_writeEnable=0.
  - A FIFO entry with rd=0 is still popped.
- FIFO:
  - Push when md_valid & md_ready; md_ready = (count != DEPTH), derived from registered state.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed entry becomes poppable no earlier than the following cycle.
- Anti-starvation:
  - Counter increments each cycle in which the ALU wins while the FIFO is non-empty.
  - Counter clears on any pop or when the FIFO is empty.
  - stall_alu = (counter == STARVE_LIMIT), combinational from the register.
  - During that cycle a pop occurs, and the counter clears.
- Scoreboard:
  - md_issue with md_issue_rd!=0 sets pending[md_issue_rd].
  - A popped FIFO entry with rd!=0 clears pending[rd].
  - Set and clear of the same bit in one cycle: set wins.
  - ALU writes never touch pending.
  - pending[0] is hard 0.
  - Issuing to an already-pending rd is an upstream error; the bit simply stays 1.
- Reset mid-operation: all FIFO contents and pending bits are discarded; no regfile write occurs on the reset edge.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when the FIFO is empty, alu_valid=0 and stall_alu=0, an accepted md handshake goes directly to the write-port registers (latency 1). The entry is not enqueued and pending is cleared in that same cycle.
- Undefined: every mult/div result is enqueued first, giving minimum latency 2 from handshake to ctrl_writeEnable.

Decomposition:
- Package wb_pkg: REG_W=5, DATA_W=32, NUM_REGS=32, and a source-select enum (SRC_NONE, SRC_ALU, SRC_MD).
- Sub-module wb_fifo: parameterised DEPTH x (REG_W+DATA_W) synchronous FIFO with full/empty/count outputs and active-low async reset.
- Arbitration, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- alu_valid=1, rd=3, data=0xDEADBEEF at cycle N -> ctrl_writeEnable=1, writeReg=3, data=0xDEADBEEF at N+1.
- alu_valid=1, rd=0 -> ctrl_writeEnable stays 0.
- md_issue rd=7 -> pending[7]=1. Then md handshake rd=7, data=0x55 with ALU idle -> write r7=0x55 two cycles after the handshake (one with WB_BYPASS_EN), and pending[7]=0 when that write is presented.
- Push 4 md results while alu_valid held 1 -> md_ready=0 after the 4th. After 8 ALU wins, stall_alu=1 for exactly one cycle and the FIFO head is written.
- md_issue and pop of the same rd=9 in one cycle -> pending[9] remains 1.
- Assert ctrl_reset with 3 FIFO entries and pending bits set -> all outputs 0 immediately. After release, no stale writes occur and md_ready=1.
